// File: rtl/cle_param_if.sv
// Bus bundle for cle_param: start/finish handshake, pattern-ROM read port and
// result-SRAM write port. master = labelling engine, slave = ROM/SRAM/controller side.
interface cle_param_if #(
  parameter int unsigned LOG_W = 5,
  parameter int unsigned LOG_H = 5,
  parameter int unsigned LBL_W = 8
);
  localparam int unsigned AW = LOG_W + LOG_H;

  logic             start;
  logic [7:0]       rom_q;
  logic [AW-4:0]    rom_a;
  logic [LBL_W-1:0] sram_q;
  logic [AW-1:0]    sram_a;
  logic [LBL_W-1:0] sram_d;
  logic             sram_wen;
  logic             busy;
  logic             finish;
  logic [LBL_W-1:0] group_cnt;

  modport master (
    input  start, rom_q, sram_q,
    output rom_a, sram_a, sram_d, sram_wen, busy, finish, group_cnt
  );

  modport slave (
    output start, rom_q, sram_q,
    input  rom_a, sram_a, sram_d, sram_wen, busy, finish, group_cnt
  );
endinterface

// File: rtl/cle_param.sv
// Connected-component labeller: loads a packed bitmap from ROM, flood-fills each group
// with a pixel stack and writes one label per pixel to SRAM. CLE_CONN8_EN selects 8-connectivity.
module cle_param #(
  parameter int unsigned LOG_W = 5,
  parameter int unsigned LOG_H = 5,
  parameter int unsigned LBL_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  cle_param_if.master bus
);
  localparam int unsigned AW  = LOG_W + LOG_H;
  localparam int unsigned N   = 1 << AW;
  localparam int unsigned RAW = AW - 3;
  localparam logic [RAW:0] LD_END = {1'b1, {RAW{1'b0}}};
`ifdef CLE_CONN8_EN
  localparam logic [2:0] NB_LAST = 3'd7;
`else
  localparam logic [2:0] NB_LAST = 3'd3;
`endif

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_FPOP, S_FNB, S_DONE} state_e;

  state_e           state_q;
  logic [N-1:0]     img_q;
  logic [N-1:0]     vis_q;
  logic [AW-1:0]    stk_q [N];
  logic [AW:0]      sp_q;
  logic [AW-1:0]    s_q;
  logic [AW-1:0]    cur_q;
  logic [RAW:0]     ld_q;
  logic [2:0]       nb_q;
  logic             last_q;
  logic [LBL_W-1:0] lbl_q;
  logic [RAW-1:0]   rom_a_q;
  logic [AW-1:0]    sram_a_q;
  logic [LBL_W-1:0] sram_d_q;
  logic             sram_wen_q;
  logic             busy_q;
  logic             finish_q;
  logic [LBL_W-1:0] gcnt_q;

  assign bus.rom_a     = rom_a_q;
  assign bus.sram_a    = sram_a_q;
  assign bus.sram_d    = sram_d_q;
  assign bus.sram_wen  = sram_wen_q;
  assign bus.busy      = busy_q;
  assign bus.finish    = finish_q;
  assign bus.group_cnt = gcnt_q;

  logic [LOG_H-1:0] row, nb_row;
  logic [LOG_W-1:0] col, nb_col;
  logic             up, dn, lf, rt, nb_in, nb_ok, seed, push_en, start_ok;
  logic [AW-1:0]    nb_idx, push_idx, top_idx;
  logic [AW:0]      sp_inc, sp_dec, sp_nxt;
  logic [RAW-1:0]   ld_m1;
  logic [LBL_W-1:0] lbl_nxt;

  assign row = cur_q[AW-1:LOG_W];
  assign col = cur_q[LOG_W-1:0];

  // Neighbour offset for the current FILL step, in fixed examination order
  always_comb begin
    up = 1'b0;
    dn = 1'b0;
    lf = 1'b0;
    rt = 1'b0;
`ifdef CLE_CONN8_EN
    case (nb_q)
      3'd0:    begin up = 1'b1; lf = 1'b1; end
      3'd1:    up = 1'b1;
      3'd2:    begin up = 1'b1; rt = 1'b1; end
      3'd3:    lf = 1'b1;
      3'd4:    rt = 1'b1;
      3'd5:    begin dn = 1'b1; lf = 1'b1; end
      3'd6:    dn = 1'b1;
      default: begin dn = 1'b1; rt = 1'b1; end
    endcase
`else
    case (nb_q)
      3'd0:    up = 1'b1;
      3'd1:    lf = 1'b1;
      3'd2:    rt = 1'b1;
      default: dn = 1'b1;
    endcase
`endif
  end

  assign nb_row   = up ? row - LOG_H'(1) : (dn ? row + LOG_H'(1) : row);
  assign nb_col   = lf ? col - LOG_W'(1) : (rt ? col + LOG_W'(1) : col);
  assign nb_idx   = {nb_row, nb_col};
  assign nb_in    = !(up && row == '0) && !(dn && row == '1) &&
                    !(lf && col == '0) && !(rt && col == '1);
  assign nb_ok    = nb_in && img_q[nb_idx] && !vis_q[nb_idx];
  assign seed     = img_q[s_q] && !vis_q[s_q];
  assign push_en  = (state_q == S_SCAN && seed) || (state_q == S_FNB && nb_ok);
  assign push_idx = (state_q == S_SCAN) ? s_q : nb_idx;
  assign sp_inc   = sp_q + (AW+1)'(1);
  assign sp_dec   = sp_q - (AW+1)'(1);
  assign sp_nxt   = nb_ok ? sp_inc : sp_q;
  assign top_idx  = stk_q[sp_dec[AW-1:0]];
  assign ld_m1    = RAW'(ld_q - (RAW+1)'(1));
  assign lbl_nxt  = (lbl_q == '1) ? lbl_q : lbl_q + LBL_W'(1);
  assign start_ok = bus.start && (state_q == S_IDLE || state_q == S_DONE);

  // Bulk storage deliberately has no reset; every run reloads the bitmap and clears visited
  always_ff @(posedge clk) begin
    if (start_ok)
      vis_q <= '0;
    else if (push_en)
      vis_q[push_idx] <= 1'b1;
    if (push_en)
      stk_q[sp_q[AW-1:0]] <= push_idx;
    if (state_q == S_LOAD && ld_q != '0)
      for (int unsigned j = 0; j < 8; j++)
        img_q[{ld_m1, 3'(j)}] <= bus.rom_q[7-j];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sp_q       <= '0;
      s_q        <= '0;
      cur_q      <= '0;
      ld_q       <= '0;
      nb_q       <= '0;
      last_q     <= 1'b0;
      lbl_q      <= '0;
      rom_a_q    <= '0;
      sram_a_q   <= '0;
      sram_d_q   <= '0;
      sram_wen_q <= 1'b1;
      busy_q     <= 1'b0;
      finish_q   <= 1'b0;
      gcnt_q     <= '0;
    end else begin
      sram_wen_q <= 1'b1;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_q  <= S_LOAD;
            busy_q   <= 1'b1;
            finish_q <= 1'b0;
            sp_q     <= '0;
            lbl_q    <= '0;
            gcnt_q   <= '0;
            ld_q     <= '0;
            rom_a_q  <= '0;
          end
        end
        S_LOAD: begin
          ld_q    <= ld_q + (RAW+1)'(1);
          rom_a_q <= rom_a_q + RAW'(1);
          if (ld_q == LD_END) begin
            state_q <= S_SCAN;
            s_q     <= '0;
          end
        end
        S_SCAN: begin
          last_q <= (s_q == '1);
          s_q    <= s_q + AW'(1);
          if (!img_q[s_q]) begin
            sram_a_q   <= s_q;
            sram_d_q   <= '0;
            sram_wen_q <= 1'b0;
          end else if (seed) begin
            lbl_q   <= lbl_nxt;
            gcnt_q  <= lbl_nxt;
            sp_q    <= sp_inc;
            state_q <= S_FPOP;
          end
          if (s_q == '1 && !seed) begin
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            finish_q <= 1'b1;
          end
        end
        S_FPOP: begin
          sp_q       <= sp_dec;
          cur_q      <= top_idx;
          sram_a_q   <= top_idx;
          sram_d_q   <= lbl_q;
          sram_wen_q <= 1'b0;
          nb_q       <= '0;
          state_q    <= S_FNB;
        end
        S_FNB: begin
          nb_q <= nb_q + 3'd1;
          sp_q <= sp_nxt;
          // s_q already points past the seed, so resuming SCAN continues at s+1
          if (nb_q == NB_LAST) begin
            if (sp_nxt != '0) begin
              state_q <= S_FPOP;
            end else if (last_q) begin
              state_q  <= S_DONE;
              busy_q   <= 1'b0;
              finish_q <= 1'b1;
            end else begin
              state_q <= S_SCAN;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cle_param.sv
// Bench for cle_param (32x32, 8-bit labels): ROM/SRAM models, BFS raster-order
// reference labelling, directed boundary images, random images, restart and mid-run reset.
module tb_cle_param;
  localparam int unsigned LOG_W = 5;
  localparam int unsigned LOG_H = 5;
  localparam int unsigned LBL_W = 8;
  localparam int W   = 32;
  localparam int H   = 32;
  localparam int N   = W * H;
  localparam int NWD = N / 8;
  localparam int L   = 255;
`ifdef CLE_CONN8_EN
  localparam bit CONN8 = 1'b1;
  localparam int K     = 8;
`else
  localparam bit CONN8 = 1'b0;
  localparam int K     = 4;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cle_param_if #(.LOG_W(LOG_W), .LOG_H(LOG_H), .LBL_W(LBL_W)) bus ();

  cle_param #(.LOG_W(LOG_W), .LOG_H(LOG_H), .LBL_W(LBL_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  assign bus.sram_q = '0;

  logic [7:0] rom [NWD];
  always @(posedge clk) bus.rom_q <= rom[bus.rom_a];

  int run_id = 0;
  int wrun [N];
  int wcnt [N];
  int mem  [N];

  always @(negedge clk) begin
    if (bus.sram_wen === 1'b0) begin
      int a;
      a = int'(bus.sram_a);
      if (wrun[a] != run_id) begin
        wrun[a] = run_id;
        wcnt[a] = 0;
      end
      wcnt[a] = wcnt[a] + 1;
      mem[a]  = int'(bus.sram_d);
    end
  end

  bit img [N];
  int exp_lbl [N];
  int exp_gc, exp_cyc, last_cyc;
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: raster scan, breadth-first flood per new group, saturating label
  function automatic void build_model();
    int q[$];
    bit seen [N];
    int lbl = 0;
    int f = 0;
    for (int i = 0; i < N; i++) begin
      exp_lbl[i] = 0;
      seen[i] = 1'b0;
    end
    for (int s = 0; s < N; s++) begin
      if (img[s]) begin
        f++;
        if (!seen[s]) begin
          lbl = (lbl < L) ? lbl + 1 : L;
          seen[s] = 1'b1;
          q.push_back(s);
          while (q.size() > 0) begin
            int p, r, c;
            p = q.pop_front();
            r = p / W;
            c = p % W;
            exp_lbl[p] = lbl;
            for (int dr = -1; dr <= 1; dr++)
              for (int dc = -1; dc <= 1; dc++) begin
                int rr, cc;
                rr = r + dr;
                cc = c + dc;
                if ((dr != 0 || dc != 0) && (CONN8 || dr == 0 || dc == 0) &&
                    rr >= 0 && rr < H && cc >= 0 && cc < W &&
                    img[rr*W+cc] && !seen[rr*W+cc]) begin
                  seen[rr*W+cc] = 1'b1;
                  q.push_back(rr*W+cc);
                end
              end
          end
        end
      end
    end
    exp_gc  = lbl;
    exp_cyc = NWD + 1 + N + f * (K + 1);
  endfunction

  task automatic check_reset_vals(input string nm);
    check({nm, "_rom_a"},    bus.rom_a, 0);
    check({nm, "_sram_a"},   bus.sram_a, 0);
    check({nm, "_sram_d"},   bus.sram_d, 0);
    check({nm, "_sram_wen"}, bus.sram_wen, 1);
    check({nm, "_busy"},     bus.busy, 0);
    check({nm, "_finish"},   bus.finish, 0);
    check({nm, "_gcnt"},     bus.group_cnt, 0);
  endtask

  task automatic clr_img();
    for (int i = 0; i < N; i++) img[i] = 1'b0;
  endtask

  task automatic rand_img(input int dens);
    for (int i = 0; i < N; i++) img[i] = ($urandom_range(0, 99) < dens);
  endtask

  // One run; abort_at>0 resets the DUT at that cycle, pulse_at>0 pulses start mid-run
  task automatic run(input string nm, input int abort_at, input int pulse_at);
    int nbad, nwb;
    bit done;
    for (int w = 0; w < NWD; w++)
      for (int j = 0; j < 8; j++) rom[w][7-j] = img[w*8+j];
    build_model();
    run_id++;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    last_cyc = 0;
    #1;
    check({nm, "_busy_on"}, bus.busy, 1);
    check({nm, "_fin_off"}, bus.finish, 0);
    @(negedge clk);
    bus.start = 1'b0;
    done = 1'b0;
    while (!done) begin
      @(posedge clk);
      last_cyc++;
      #1;
      if (abort_at > 0 && last_cyc == abort_at) begin
        reset = 1'b1;
        #1;
        check_reset_vals({nm, "_abort"});
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      bus.start = (last_cyc == pulse_at);
      if (bus.finish) done = 1'b1;
      else if (last_cyc > exp_cyc + 50) begin
        check({nm, "_timeout"}, last_cyc, exp_cyc);
        done = 1'b1;
      end
    end
    bus.start = 1'b0;
    check({nm, "_latency"}, last_cyc, exp_cyc);
    check({nm, "_gcnt"}, bus.group_cnt, exp_gc);
    check({nm, "_busy_off"}, bus.busy, 0);
    @(negedge clk);
    #1;
    nbad = 0;
    nwb  = 0;
    for (int a = 0; a < N; a++) begin
      if (wrun[a] != run_id || wcnt[a] != 1) nwb++;
      else if (mem[a] != exp_lbl[a]) nbad++;
    end
    check({nm, "_write_once_bad"}, nwb, 0);
    check({nm, "_label_bad"}, nbad, 0);
  endtask

  initial begin
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    reset = 1'b0;

    clr_img();
    run("zero", 0, 0);
    check("zero_cycles", last_cyc, 1153);
    check("zero_gc", bus.group_cnt, 0);

    for (int i = 0; i < N; i++) img[i] = 1'b1;
    run("ones", 0, 0);
    check("ones_cycles", last_cyc, CONN8 ? 10369 : 6273);
    check("ones_first", mem[0], 1);
    check("ones_last", mem[N-1], 1);

    clr_img();
    img[0]  = 1'b1;
    img[33] = 1'b1;
    run("diag", 0, 0);
    check("diag_p0", mem[0], 1);
    check("diag_p33", mem[33], CONN8 ? 1 : 2);
    check("diag_gc", bus.group_cnt, CONN8 ? 1 : 2);

    clr_img();
    img[31] = 1'b1;
    img[32] = 1'b1;
    run("wrap", 0, 0);
    check("wrap_p31", mem[31], 1);
    check("wrap_p32", mem[32], 2);
    check("wrap_gc", bus.group_cnt, 2);

    clr_img();
    for (int r = 0; r < H; r += 2)
      for (int c = 0; c < W; c += 2) img[r*W+c] = 1'b1;
    run("sat", 0, 0);
    check("sat_gc", bus.group_cnt, 255);
    check("sat_p986", mem[986], 254);
    check("sat_p988", mem[988], 255);
    check("sat_p990", mem[990], 255);

    rand_img(20);
    run("rnd20", 0, 0);
    rand_img(45);
    run("rnd45_busystart", 0, 300);
    rand_img(60);
    run("rnd60", 0, 0);

    for (int i = 0; i < N; i++) img[i] = 1'b1;
    run("abort", NWD + 1 + 60, 0);
    rand_img(50);
    run("after_abort", 0, 0);
    rand_img(80);
    run("rnd80", 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
